// File: rtl/psw_pkg.sv
// Shared PSW field layout, bit indices and default implemented-bit mask.
package psw_pkg;

   localparam int unsigned PSW_W = 16;

   localparam int unsigned PSW_C   = 0;
   localparam int unsigned PSW_Z   = 1;
   localparam int unsigned PSW_N   = 2;
   localparam int unsigned PSW_SLP = 3;
   localparam int unsigned PSW_V   = 4;

   localparam int unsigned PSW_CPRI_LSB = 5;
   localparam int unsigned PSW_CPRI_MSB = 7;
   localparam int unsigned PSW_PPRI_LSB = 13;
   localparam int unsigned PSW_PPRI_MSB = 15;

   localparam logic [PSW_W-1:0] PSW_WR_MASK_DEFAULT = 16'hE0FF;

   typedef struct packed {
      logic [2:0] ppri;
      logic [4:0] rsvd;
      logic [2:0] cpri;
      logic       v;
      logic       slp;
      logic       n;
      logic       z;
      logic       c;
   } psw_t;

   // Apply the implemented-bit mask to a raw PSW value.
   function automatic psw_t psw_mask(input logic [PSW_W-1:0] raw, input logic [PSW_W-1:0] msk);
      return psw_t'(raw & msk);
   endfunction

endpackage

// File: rtl/psw_stack.sv
// LIFO of saved PSW values; refuses pushes when full and pops when empty.
module psw_stack
   import psw_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  psw_t din,
   output psw_t top,
   output logic full,
   output logic empty,
   output logic overflow_c,
   output logic underflow_c
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             do_push;
   logic             do_pop;
   psw_t             mem [DEPTH];

   assign full   = (sp == SP_W'(DEPTH));
   assign empty  = (sp == SP_W'(0));

   assign do_push = push & ~full;
   assign do_pop  = pop & ~push & ~empty;

   assign overflow_c  = push & full;
   assign underflow_c = pop & ~push & empty;

   assign wr_idx = IDX_W'(sp);
   assign rd_idx = IDX_W'(sp - SP_W'(1));
   assign top    = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (do_push) begin
         sp <= sp + SP_W'(1);
      end else if (do_pop) begin
         sp <= sp - SP_W'(1);
      end
   end

   // Storage is don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/psw_unit.sv
// Architectural PSW register: ALU flag merge, explicit writes and exception save/restore.
module psw_unit
   import psw_pkg::*;
#(
   parameter int unsigned      DEPTH     = 4,
   parameter logic [15:0]      RESET_PSW = 16'h0000,
   parameter logic [15:0]      WR_MASK   = PSW_WR_MASK_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        stall,
   input  logic [15:0] alu_psw,
   input  logic [15:0] alu_msk,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        push,
   input  logic [15:0] entry_psw,
   input  logic        pop,
   input  logic        clr_err,
   output logic [15:0] psw,
   output logic        carry_flag,
   output logic [15:0] psw_next,
   output logic        stk_full,
   output logic        stk_empty,
   output logic        stk_err
);

   logic [15:0] merged_c;
   logic        push_q;
   logic        pop_q;
   logic        ovf_c;
   logic        unf_c;
   psw_t        stk_top;
   psw_t        stk_din;

   assign merged_c = ex_valid ? ((psw & ~alu_msk) | (alu_psw & alu_msk)) : psw;

   // Stall freezes every request before it reaches the stack.
   assign push_q  = push & ~stall;
   assign pop_q   = pop & ~stall;
   assign stk_din = psw_mask(merged_c, WR_MASK);

   psw_stack #(
      .DEPTH (DEPTH)
   ) u_stack (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push_q),
      .pop         (pop_q),
      .din         (stk_din),
      .top         (stk_top),
      .full        (stk_full),
      .empty       (stk_empty),
      .overflow_c  (ovf_c),
      .underflow_c (unf_c)
   );

   // One action per cycle: push > pop > explicit write > ALU merge.
   always_comb begin
      psw_next = psw;
      if (stall) begin
         psw_next = psw;
      end else if (push) begin
         psw_next = entry_psw & WR_MASK;
      end else if (pop) begin
         psw_next = stk_empty ? psw : (16'(stk_top) & WR_MASK);
      end else if (wr_en) begin
         psw_next = wr_data & WR_MASK;
      end else begin
         psw_next = merged_c & WR_MASK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psw <= RESET_PSW & WR_MASK;
      end else begin
         psw <= psw_next;
      end
   end

   // Sticky error; a fresh overflow/underflow outranks a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stk_err <= 1'b0;
      end else if (ovf_c || unf_c) begin
         stk_err <= 1'b1;
      end else if (clr_err && !stall) begin
         stk_err <= 1'b0;
      end
   end

   assign carry_flag = psw[PSW_C];

endmodule

// File: tb/tb_psw_unit.sv
// Directed table-driven check of psw_unit with hand-computed expectations.
module tb_psw_unit;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        stall;
   logic [15:0] alu_psw;
   logic [15:0] alu_msk;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        push;
   logic [15:0] entry_psw;
   logic        pop;
   logic        clr_err;
   logic [15:0] psw;
   logic        carry_flag;
   logic [15:0] psw_next;
   logic        stk_full;
   logic        stk_empty;
   logic        stk_err;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic        ev;
      logic        st;
      logic [15:0] ap;
      logic [15:0] am;
      logic        we;
      logic [15:0] wd;
      logic        pu;
      logic [15:0] ep;
      logic        po;
      logic        ce;
      logic [15:0] e_psw;
      logic        e_full;
      logic        e_empty;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   psw_unit #(
      .DEPTH     (4),
      .RESET_PSW (16'h0000),
      .WR_MASK   (16'hE0FF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid   (ex_valid),
      .stall      (stall),
      .alu_psw    (alu_psw),
      .alu_msk    (alu_msk),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .push       (push),
      .entry_psw  (entry_psw),
      .pop        (pop),
      .clr_err    (clr_err),
      .psw        (psw),
      .carry_flag (carry_flag),
      .psw_next   (psw_next),
      .stk_full   (stk_full),
      .stk_empty  (stk_empty),
      .stk_err    (stk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic ev, logic st, logic [15:0] ap, logic [15:0] am,
                               logic we, logic [15:0] wd, logic pu, logic [15:0] ep,
                               logic po, logic ce, logic [15:0] e_psw,
                               logic e_full, logic e_empty, logic e_err);
      vec_t v;
      v.ev = ev; v.st = st; v.ap = ap; v.am = am; v.we = we; v.wd = wd;
      v.pu = pu; v.ep = ep; v.po = po; v.ce = ce; v.e_psw = e_psw;
      v.e_full = e_full; v.e_empty = e_empty; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
   endtask

   task automatic drive(input vec_t v);
      ex_valid = v.ev; stall = v.st; alu_psw = v.ap; alu_msk = v.am;
      wr_en = v.we; wr_data = v.wd; push = v.pu; entry_psw = v.ep;
      pop = v.po; clr_err = v.ce;
   endtask

   task automatic check_state(input int idx, input logic [15:0] e_psw,
                              input logic e_full, input logic e_empty, input logic e_err);
      chk("psw",        idx, psw,                 e_psw);
      chk("carry_flag", idx, 16'(carry_flag),     16'(e_psw[0]));
      chk("stk_full",   idx, 16'(stk_full),       16'(e_full));
      chk("stk_empty",  idx, 16'(stk_empty),      16'(e_empty));
      chk("stk_err",    idx, 16'(stk_err),        16'(e_err));
   endtask

   initial begin
      vec_t idle;
      pass_cnt  = 0;
      total_cnt = 0;
      idle = mk(0,0,16'h0,16'h0,0,16'h0,0,16'h0,0,0,16'h0,0,1,0);
      drive(idle);
      rst_n = 1'b0;

      //           ev st ap       am       we wd       pu ep       po ce  psw     f e err
      vq.push_back(mk(1,0,16'h0017,16'h0003,0,16'h0000,0,16'h0000,0,0,16'h0003,0,1,0));
      vq.push_back(mk(1,0,16'h0000,16'h0001,0,16'h0000,0,16'h0000,0,0,16'h0002,0,1,0));
      vq.push_back(mk(1,0,16'h0001,16'h0001,0,16'h0000,0,16'h0000,0,0,16'h0003,0,1,0));
      vq.push_back(mk(1,1,16'hFFFF,16'hFFFF,1,16'h1234,1,16'h00E0,0,0,16'h0003,0,1,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'h00E0,0,0,16'h00E0,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h0003,0,1,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,1,16'h0001,0,16'h0000,0,0,16'h0001,0,1,0));
      vq.push_back(mk(1,0,16'h0004,16'h0004,0,16'h0000,1,16'h00E0,0,0,16'h00E0,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'h0011,0,0,16'h0011,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'h0022,0,0,16'h0022,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'h0033,0,0,16'h0033,1,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'h0044,0,0,16'h0044,1,0,1));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,0,1,16'h0044,1,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h0022,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h0011,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h00E0,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h0005,0,1,0));
      vq.push_back(mk(1,0,16'hFFFF,16'hFFFF,0,16'h0000,0,16'h0000,1,0,16'h0005,0,1,1));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,0,1,16'h0005,0,1,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,1,16'h0005,0,1,1));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'h0066,1,1,16'h0066,0,0,0));
      vq.push_back(mk(1,0,16'h0000,16'hFFFF,1,16'hFFFF,0,16'h0000,0,0,16'hE0FF,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,1,16'h1234,0,16'h0000,1,0,16'h0005,0,1,0));
      vq.push_back(mk(1,0,16'hFFFF,16'h0010,0,16'h0000,0,16'h0000,0,0,16'h0015,0,1,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,1,16'hFFFF,0,0,16'hE0FF,0,0,0));
      vq.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h0015,0,1,0));
      vq.push_back(mk(0,1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,1,0,16'h0015,0,1,0));

      // Reset state
      #12;
      check_state(-1, 16'h0000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state(-2, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Idle with no valid ALU result holds the PSW
      for (int i = 0; i < 10; i++) begin
         drive(idle);
         @(posedge clk);
         #1;
         chk("idle_psw", i, psw, 16'h0000);
      end

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         #2;
         chk("psw_next", i, psw_next, vq[i].e_psw);
         @(posedge clk);
         #1;
         check_state(i, vq[i].e_psw, vq[i].e_full, vq[i].e_empty, vq[i].e_err);
      end

      // Reset asserted mid-cycle while a push is pending abandons it
      drive(mk(0,0,16'h0,16'h0,0,16'h0,1,16'h00AA,0,0,16'h0,0,1,0));
      #2;
      rst_n = 1'b0;
      #1;
      check_state(100, 16'h0000, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_state(101, 16'h0000, 1'b0, 1'b1, 1'b0);
      drive(idle);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state(102, 16'h0000, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/psw_unit.md
Name: psw_unit

Overview:
- Program Status Word register stage, directly downstream of the execute-stage ALU units (ADD/ADDC/SUB/SUBC/logic).
- Merges each ALU's psw_out under its psw_msk into the architectural PSW.
- Feeds the registered carry flag back to the carry_in of ADDC/SUBC.
- Holds a small shadow stack so PSW is saved on exception entry and restored on RETI; also accepts explicit PSW writes from a MOV-to-PSW path.

Parameters:
- DEPTH, 4: shadow-stack entries (power of two, 2..16).
- RESET_PSW, 16'h0000: PSW value after reset.
- WR_MASK, 16'hE0FF: implemented PSW bits; unimplemented bits always read 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage holds a valid ALU result this cycle
- stall  in  1  pipeline stall; freezes all PSW and stack state
- alu_psw  in  16  flag values from the active ALU (C=bit0, Z=1, N=2, SLP=3, V=4)
- alu_msk  in  16  bits of alu_psw to apply
- wr_en  in  1  explicit full-PSW write
- wr_data  in  16  explicit write value
- push  in  1  exception entry: save PSW, load entry_psw
- entry_psw  in  16  PSW loaded on push
- pop  in  1  RETI: restore PSW from stack
- clr_err  in  1  clears stk_err
- psw  out  16  registered PSW
- carry_flag  out  1  psw[0], to ALU carry_in
- psw_next  out  16  combinational next-PSW (bypass for same-cycle consumers)
- stk_full  out  1  DEPTH entries held
- stk_empty  out  1  zero entries held
- stk_err  out  1  sticky overflow/underflow

Behaviour:
- Reset (async, rst_n=0):
  - psw=RESET_PSW&WR_MASK, stack pointer=0.
  - stk_empty=1, stk_full=0, stk_err=0.
  - Stack contents don't-care.
  - Mid-operation reset abandons any push/pop.
- All updates happen on the rising clk edge. Nothing changes while stall=1, including push, pop, clr_err and stk_err set.
- Merge: m = (psw & ~alu_msk) | (alu_psw & alu_msk) when ex_valid, else psw.
- Priority, one action per cycle:
  1. push: stack[sp] <= m; psw <= entry_psw; sp++. The ALU result of the same cycle is committed into the saved value.
  2. pop: psw <= stack[sp-1]; sp--. A concurrent ex_valid merge is discarded.
  3. wr_en: psw <= wr_data. A concurrent ALU merge is discarded.
  4. Otherwise psw <= m.
- All written values are ANDed with WR_MASK.
- push and pop together: push wins; pop is ignored with no error.
- Overflow (push while stk_full):
  - Stack and sp unchanged.
  - psw still loads entry_psw.
  - stk_err <= 1.
- Underflow (pop while stk_empty): psw and sp unchanged, stk_err <= 1.
- stk_err clears on clr_err when no new error occurs that cycle; a new error wins.
- psw_next equals the value psw will take at the next edge (psw itself when stalled). carry_flag is registered, with zero-cycle latency from psw.
- Sizing: sp is clog2(DEPTH)+1 bits, range 0..DEPTH. stk_full = (sp==DEPTH); stk_empty = (sp==0).

Decomposition:
- Shared package psw_pkg:
  - bit-index constants PSW_C, PSW_Z, PSW_N, PSW_SLP, PSW_V
  - priority field positions (PSW_CPRI 7:5, PSW_PPRI 15:13)
  - typedef psw_t (16-bit packed struct)
  - default WR_MASK
- One sub-module: psw_stack, a LIFO of psw_t with push/pop/full/empty/overflow/underflow flags. psw_unit holds merge/priority logic and the PSW register.

Test Plan:
- Reset then idle: after rst_n release, psw=0000, carry_flag=0, stk_empty=1, stk_err=0. Hold ex_valid=0 for 10 cycles -> psw unchanged.
- Masked merge: psw=0000; ex_valid=1, alu_psw=0017, alu_msk=0003 -> psw=0003. Next alu_psw=0000, alu_msk=0001 -> psw=0002, carry_flag=0.
- Stall: psw=0003, stall=1 with ex_valid, wr_en and push all asserted -> psw=0003, sp unchanged, psw_next=0003. On stall release, push is taken.
- Push/pop nesting with DEPTH=4: psw=0001, ALU msk=0004/psw=0004 plus push with entry_psw=00E0 same cycle -> psw=00E0, stack top=0005. Three more pushes -> stk_full=1. Fifth push -> stk_err=1, psw=entry_psw, sp=4. Four pops -> last restored psw=0005, stk_empty=1.
- Underflow and clear: pop while empty -> psw unchanged, stk_err=1. clr_err -> stk_err=0. clr_err together with another empty pop -> stk_err stays 1.
- Priority and masking: push+pop same cycle -> push only, no error. wr_en=FFFF with ex_valid -> psw=E0FF. wr_en with pop when not empty -> pop result.
